// File: rtl/div_unit.sv
// Iterative 32-bit integer divider: radix-2 restoring division, one quotient bit per cycle.
// Handles signed/unsigned quotient and remainder, divide-by-zero, cancel and result handshake.
module div_unit (
  input  logic        clk,
  input  logic        resetn,
  input  logic        div_valid,
  output logic        div_ready,
  input  logic [1:0]  div_op,
  input  logic [31:0] div_src1,
  input  logic [31:0] div_src2,
  input  logic        div_cancel,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] div_result
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state_reg, state_next;
  logic [5:0]  cnt_reg;
  logic [1:0]  op_reg;
  logic        q_neg_reg, r_neg_reg, zero_reg;
  logic [31:0] quo_reg, rem_reg, divisor_reg, src1_reg, result_reg;

  logic        accept;
  logic        signed_op;
  logic [31:0] abs1, abs2;
  logic [32:0] partial, diff;
  logic        ge;
  logic [31:0] q_fix, r_fix, final_res;

  assign accept    = (state_reg == IDLE) && div_valid && !div_cancel;
  assign signed_op = !div_op[1];
  assign abs1      = (signed_op && div_src1[31]) ? (32'd0 - div_src1) : div_src1;
  assign abs2      = (signed_op && div_src2[31]) ? (32'd0 - div_src2) : div_src2;

  // Shift the next dividend bit into the partial remainder and try to subtract.
  assign partial = {rem_reg, quo_reg[31]};
  assign diff    = partial - {1'b0, divisor_reg};
  assign ge      = !diff[32];

  assign q_fix = q_neg_reg ? (32'd0 - quo_reg) : quo_reg;
  assign r_fix = r_neg_reg ? (32'd0 - rem_reg) : rem_reg;

  // Divide by zero bypasses sign correction so the remainder is the raw dividend.
  always_comb begin
    final_res = op_reg[0] ? r_fix : q_fix;
    if (zero_reg) begin
      final_res = op_reg[0] ? src1_reg : 32'hFFFF_FFFF;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    div_ready  = 1'b0;
    res_valid  = 1'b0;
    case (state_reg)
      IDLE: begin
        div_ready = 1'b1;
        if (accept) state_next = CALC;
      end
      CALC: begin
        if (div_cancel) state_next = IDLE;
        else if (cnt_reg == 6'd32) state_next = DONE;
      end
      DONE: begin
        res_valid = 1'b1;
        if (div_cancel || res_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_reg     <= 6'd0;
      op_reg      <= 2'b00;
      q_neg_reg   <= 1'b0;
      r_neg_reg   <= 1'b0;
      zero_reg    <= 1'b0;
      quo_reg     <= 32'd0;
      rem_reg     <= 32'd0;
      divisor_reg <= 32'd0;
      src1_reg    <= 32'd0;
      result_reg  <= 32'd0;
    end else if (accept) begin
      cnt_reg     <= 6'd0;
      op_reg      <= div_op;
      q_neg_reg   <= signed_op && (div_src1[31] ^ div_src2[31]);
      r_neg_reg   <= signed_op && div_src1[31];
      zero_reg    <= (div_src2 == 32'd0);
      quo_reg     <= abs1;
      rem_reg     <= 32'd0;
      divisor_reg <= abs2;
      src1_reg    <= div_src1;
    end else if (state_reg == CALC) begin
      if (cnt_reg != 6'd32) begin
        rem_reg <= ge ? diff[31:0] : partial[31:0];
        quo_reg <= {quo_reg[30:0], ge};
        cnt_reg <= cnt_reg + 6'd1;
      end else if (!div_cancel) begin
        result_reg <= final_res;
      end
    end
  end

  assign div_result = result_reg;

endmodule

// File: tb/tb_div_unit.sv
// Randomized and directed bench for div_unit against an arithmetic reference model.
// Every transaction prints one line; failures print a FAIL line.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        resetn;
  logic        div_valid;
  logic        div_ready;
  logic [1:0]  div_op;
  logic [31:0] div_src1, div_src2;
  logic        div_cancel;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] div_result;

  int          total = 0;
  int          bad = 0;
  logic        exp_armed = 1'b0;
  logic [31:0] exp_res = 32'd0;

  div_unit dut (
    .clk        (clk),
    .resetn     (resetn),
    .div_valid  (div_valid),
    .div_ready  (div_ready),
    .div_op     (div_op),
    .div_src1   (div_src1),
    .div_src2   (div_src2),
    .div_cancel (div_cancel),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .div_result (div_result)
  );

  always #5 clk = ~clk;

  // Reference: plain integer arithmetic plus the special cases.
  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    logic [31:0] r;
    sa = a;
    sb = b;
    if (b == 32'd0) r = op[0] ? a : 32'hFFFF_FFFF;
    else if (!op[1] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = op[0] ? 32'd0 : 32'h8000_0000;
    else if (!op[1]) r = op[0] ? 32'(sa % sb) : 32'(sa / sb);
    else r = op[0] ? (a % b) : (a / b);
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Continuous compare whenever a result is presented.
  always @(negedge clk) begin
    if (resetn && res_valid) begin
      total++;
      if (!exp_armed || div_result !== exp_res) begin
        bad++;
        $display("FAIL cmp_result: got %h expected %h armed=%0b at %0t", div_result, exp_res, exp_armed, $time);
      end
      if (div_ready) begin
        bad++;
        $display("FAIL ready_in_done: got 1 expected 0 at %0t", $time);
      end
    end
  end

  // Called at an off-edge time with the DUT idle.
  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int hold);
    int n;
    logic got;
    check("ready_before", {31'd0, div_ready}, 32'd1);
    div_valid = 1'b1; div_op = op; div_src1 = a; div_src2 = b;
    @(posedge clk); #1;
    exp_res = exp; exp_armed = 1'b1;
    check("busy_after_accept", {31'd0, div_ready}, 32'd0);
    n = 0; got = 1'b0;
    while (n < 40 && !got) begin
      if (n < 30) begin
        div_valid = 1'($urandom); div_op = 2'($urandom);
        div_src1 = $urandom; div_src2 = $urandom;
      end else begin
        div_valid = 1'b0;
      end
      @(posedge clk); #1;
      n++;
      if (res_valid) got = 1'b1;
    end
    div_valid = 1'b0;
    check("latency", 32'(n), 32'd33);
    $display("op=%0d a=%h b=%h result=%h expected=%h latency=%0d", op, a, b, div_result, exp, n);
    if (got) begin
      check("result", div_result, exp);
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        check("hold_result", div_result, exp);
        check("hold_valid", {31'd0, res_valid}, 32'd1);
      end
      res_ready = 1'b1;
      #1 check("no_ready_when_ack", {31'd0, div_ready}, 32'd0);
      @(posedge clk); #1;
      res_ready = 1'b0;
      check("ready_after_ack", {31'd0, div_ready}, 32'd1);
      check("valid_after_ack", {31'd0, res_valid}, 32'd0);
    end
    exp_armed = 1'b0;
  endtask

  task automatic cancel_op(input int at_cycle, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    div_valid = 1'b1; div_op = op; div_src1 = a; div_src2 = b;
    @(posedge clk); #1;
    div_valid = 1'b0;
    exp_res = model(op, a, b);
    exp_armed = (at_cycle >= 33);
    repeat (at_cycle) begin @(posedge clk); #1; end
    check("valid_before_cancel", {31'd0, res_valid}, {31'd0, exp_armed});
    div_cancel = 1'b1;
    @(posedge clk); #1;
    div_cancel = 1'b0;
    exp_armed = 1'b0;
    $display("cancel at cycle %0d: ready=%0b valid=%0b", at_cycle, div_ready, res_valid);
    check("cancel_ready", {31'd0, div_ready}, 32'd1);
    check("cancel_valid", {31'd0, res_valid}, 32'd0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom % 8)
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return $urandom % 16;
      4: return 32'h7FFF_FFFF;
      5: return 32'd0 - ($urandom % 16);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0; div_valid = 1'b0; div_op = 2'b00; div_src1 = 32'd0; div_src2 = 32'd0;
    div_cancel = 1'b0; res_ready = 1'b0;
    #1;
    check("reset_ready", {31'd0, div_ready}, 32'd1);
    check("reset_valid", {31'd0, res_valid}, 32'd0);
    check("reset_result", div_result, 32'd0);
    repeat (2) @(posedge clk);
    #3;
    resetn = 1'b1;
    // First request lands on the first edge after reset release.
    do_op(2'b00, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 0);
    do_op(2'b01, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 1);
    do_op(2'b10, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0FFF_FFFF, 0);
    do_op(2'b11, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 0);
    do_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
    do_op(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 0);
    do_op(2'b10, 32'h1234_5678, 32'h0000_0000, 32'hFFFF_FFFF, 0);
    do_op(2'b01, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 0);
    do_op(2'b00, 32'h0000_0064, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 5);

    // Cancel wins over a concurrent request in IDLE.
    div_valid = 1'b1; div_cancel = 1'b1;
    @(posedge clk); #1;
    div_valid = 1'b0; div_cancel = 1'b0;
    $display("idle cancel+valid: ready=%0b", div_ready);
    check("idle_cancel_ready", {31'd0, div_ready}, 32'd1);

    cancel_op(10, 2'b00, 32'hFFFF_FF00, 32'h0000_0007);
    @(posedge clk); #1;
    do_op(2'b01, 32'hFFFF_FF00, 32'h0000_0007, model(2'b01, 32'hFFFF_FF00, 32'h0000_0007), 0);
    cancel_op(33, 2'b10, 32'hDEAD_BEEF, 32'h0000_0123);
    do_op(2'b11, 32'hDEAD_BEEF, 32'h0000_0123, model(2'b11, 32'hDEAD_BEEF, 32'h0000_0123), 0);

    // Reset in the middle of a calculation.
    div_valid = 1'b1; div_op = 2'b10; div_src1 = 32'd1000; div_src2 = 32'd3;
    @(posedge clk); #1;
    div_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2 resetn = 1'b0;
    #1;
    $display("reset mid-calc: ready=%0b valid=%0b result=%h", div_ready, res_valid, div_result);
    check("midreset_ready", {31'd0, div_ready}, 32'd1);
    check("midreset_valid", {31'd0, res_valid}, 32'd0);
    check("midreset_result", div_result, 32'd0);
    repeat (2) @(posedge clk);
    #3 resetn = 1'b1;
    do_op(2'b10, 32'd1000, 32'd3, 32'd333, 0);

    for (int k = 0; k < 1500; k++) begin
      logic [1:0]  op;
      logic [31:0] a, b;
      op = 2'($urandom);
      a = pick();
      b = pick();
      do_op(op, a, b, model(op, a, b), int'($urandom % 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
